// File: rtl/psum_gather_ctrl.sv
// Row return path: round-robin gather of per-PE partial sums into a small FIFO
// that drains to the global buffer, each entry tagged with its (y, x) origin.
module psum_gather_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 4,
  parameter int NUM_ROW    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 flush,
  output logic                                 rst_busy,
  input  logic                                 cfg_load,
  input  logic [$clog2(NUM_ROW)-1:0]           cfg_y_id,
  output logic                                 cfg_err,
  input  logic [NUM_COL-1:0]                   pe_psum_valid,
  input  logic [NUM_COL*2*DATA_WIDTH-1:0]      pe_psum_data,
  output logic [NUM_COL-1:0]                   pe_psum_ready,
  output logic                                 glb_psum_valid,
  output logic [2*DATA_WIDTH-1:0]              glb_psum_data,
  output logic [$clog2(NUM_COL)-1:0]           glb_psum_x_id,
  output logic [$clog2(NUM_ROW)-1:0]           glb_psum_y_id,
  input  logic                                 glb_psum_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count
);

  localparam int PSW = 2*DATA_WIDTH;
  localparam int XW  = $clog2(NUM_COL);
  localparam int YW  = $clog2(NUM_ROW);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH+1);

  logic [1:0]     r_busy_cnt;
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic [XW-1:0]  r_rr_ptr;
  logic [YW-1:0]  r_y_id;
  logic           r_cfg_err;

  logic [PSW-1:0] r_mem_data [FIFO_DEPTH];
  logic [XW-1:0]  r_mem_x    [FIFO_DEPTH];
  logic [YW-1:0]  r_mem_y    [FIFO_DEPTH];

  logic              w_busy;
  logic              w_pop;
  logic              w_push;
  logic              w_space;
  logic              w_found;
  logic              w_cfg_ok;
  logic [NUM_COL-1:0] w_grant;
  logic [XW-1:0]     w_gnt_idx;
  logic [PSW-1:0]    w_gnt_data;
  int                w_idx;

  assign w_busy         = (r_busy_cnt != 2'd0);
  assign rst_busy       = w_busy;
  assign cfg_err        = r_cfg_err;
  assign fifo_count     = r_count;
  assign glb_psum_valid = (r_count != '0) && !w_busy;
  assign glb_psum_data  = r_mem_data[r_rd_ptr];
  assign glb_psum_x_id  = r_mem_x[r_rd_ptr];
  assign glb_psum_y_id  = r_mem_y[r_rd_ptr];

  // A pop in the flush cycle is discarded, so it must not create arbiter space either.
  assign w_pop   = glb_psum_valid && glb_psum_ready && !flush;
  assign w_space = (r_count < CW'(FIFO_DEPTH)) || w_pop;

  always_comb begin
    w_grant   = '0;
    w_gnt_idx = '0;
    w_found   = 1'b0;
    w_idx     = 0;
    if (w_space && !w_busy && !flush) begin
      for (int i = 0; i < NUM_COL; i++) begin
        w_idx = int'(r_rr_ptr) + i;
        if (w_idx >= NUM_COL) w_idx = w_idx - NUM_COL;
        if (!w_found && pe_psum_valid[w_idx]) begin
          w_found        = 1'b1;
          w_grant[w_idx] = 1'b1;
          w_gnt_idx      = w_idx[XW-1:0];
        end
      end
    end
  end

  assign pe_psum_ready = w_grant;
  assign w_push        = w_found;
  assign w_gnt_data    = pe_psum_data[w_gnt_idx*PSW +: PSW];
  assign w_cfg_ok      = cfg_load && (r_count == '0) && !w_push && !w_busy;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_busy_cnt <= 2'd2;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rr_ptr   <= '0;
      r_cfg_err  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_x[i]    <= '0;
        r_mem_y[i]    <= '0;
      end
    end else if (flush) begin
      r_busy_cnt <= 2'd2;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rr_ptr   <= '0;
      r_cfg_err  <= 1'b0;
    end else begin
      if (w_busy) r_busy_cnt <= r_busy_cnt - 2'd1;
      if (w_push) begin
        r_mem_data[r_wr_ptr] <= w_gnt_data;
        r_mem_x[r_wr_ptr]    <= w_gnt_idx;
        r_mem_y[r_wr_ptr]    <= r_y_id;
        r_wr_ptr             <= r_wr_ptr + 1'b1;
        r_rr_ptr             <= (w_gnt_idx == XW'(NUM_COL-1)) ? '0 : w_gnt_idx + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (cfg_load && !w_cfg_ok) r_cfg_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         r_y_id <= '0;
    else if (w_cfg_ok) r_y_id <= cfg_y_id;
  end

endmodule

// File: tb/tb_psum_gather_ctrl.sv
// Self-checking bench for psum_gather_ctrl: directed scenario tasks plus a
// scoreboard monitor that checks every GLB output against what the PEs sent.
module tb_psum_gather_ctrl;

  logic         clk;
  logic         rstn;
  logic         flush;
  logic         rst_busy;
  logic         cfg_load;
  logic [1:0]   cfg_y_id;
  logic         cfg_err;
  logic [3:0]   pe_psum_valid;
  logic [127:0] pe_psum_data;
  logic [3:0]   pe_psum_ready;
  logic         glb_psum_valid;
  logic [31:0]  glb_psum_data;
  logic [1:0]   glb_psum_x_id;
  logic [1:0]   glb_psum_y_id;
  logic         glb_psum_ready;
  logic [2:0]   fifo_count;

  logic [31:0]  pe_d [4];
  logic [1:0]   cur_y;
  logic [35:0]  sb_q [$];
  int           checks = 0;
  int           errors = 0;

  psum_gather_ctrl dut (
    .clk(clk), .rstn(rstn), .flush(flush), .rst_busy(rst_busy),
    .cfg_load(cfg_load), .cfg_y_id(cfg_y_id), .cfg_err(cfg_err),
    .pe_psum_valid(pe_psum_valid), .pe_psum_data(pe_psum_data),
    .pe_psum_ready(pe_psum_ready), .glb_psum_valid(glb_psum_valid),
    .glb_psum_data(glb_psum_data), .glb_psum_x_id(glb_psum_x_id),
    .glb_psum_y_id(glb_psum_y_id), .glb_psum_ready(glb_psum_ready),
    .fifo_count(fifo_count)
  );

  always_comb begin
    pe_psum_data = '0;
    for (int i = 0; i < 4; i++) pe_psum_data[i*32 +: 32] = pe_d[i];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: pushes on PE handshakes, pops and compares on GLB handshakes.
  initial begin
    logic [35:0] exp_e;
    forever begin
      @(negedge clk);
      if (!rstn || flush) begin
        sb_q.delete();
      end else begin
        if (rst_busy) begin
          checks++;
          if (pe_psum_ready !== 4'b0 || glb_psum_valid !== 1'b0) begin
            errors++;
            $display("FAIL busy_block: ready=%b glb_valid=%b, required 0000/0", pe_psum_ready, glb_psum_valid);
          end
        end
        checks++;
        if ($countones(pe_psum_ready) > 1 || (pe_psum_ready & ~pe_psum_valid) != 4'b0) begin
          errors++;
          $display("FAIL grant_onehot: ready=%b valid=%b", pe_psum_ready, pe_psum_valid);
        end
        if (glb_psum_valid && glb_psum_ready) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: data=%h x=%0d y=%0d, required no output", glb_psum_data, glb_psum_x_id, glb_psum_y_id);
          end else begin
            exp_e = sb_q.pop_front();
            if ({glb_psum_y_id, glb_psum_x_id, glb_psum_data} !== exp_e) begin
              errors++;
              $display("FAIL sb_data: got y=%0d x=%0d d=%h, required y=%0d x=%0d d=%h",
                       glb_psum_y_id, glb_psum_x_id, glb_psum_data, exp_e[35:34], exp_e[33:32], exp_e[31:0]);
            end
          end
        end
        for (int i = 0; i < 4; i++)
          if (pe_psum_valid[i] && pe_psum_ready[i]) sb_q.push_back({cur_y, 2'(i), pe_d[i]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    glb_psum_ready = 1'b1;
    @(negedge clk);
    while (fifo_count != 3'd0 && n < budget) begin
      tick();
      @(negedge clk);
      n++;
    end
    checks++;
    if (fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL drain_timeout: count=%0d, required 0", fifo_count);
    end
    tick();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rstn = 1'b1; flush = 1'b0; cfg_load = 1'b0; cfg_y_id = 2'd0;
    pe_psum_valid = 4'b0; glb_psum_ready = 1'b0; cur_y = 2'd0;
    for (int i = 0; i < 4; i++) pe_d[i] = 32'h0;
    #2 rstn = 1'b0;
    pe_psum_valid = 4'b1111;
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if (rst_busy !== 1'b1 || pe_psum_ready !== 4'b0 || glb_psum_valid !== 1'b0 ||
        fifo_count !== 3'd0 || cfg_err !== 1'b0 || glb_psum_data !== 32'h0 ||
        glb_psum_x_id !== 2'd0 || glb_psum_y_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_values: busy=%b rdy=%b gv=%b cnt=%0d err=%b d=%h, required 1/0000/0/0/0/0",
               rst_busy, pe_psum_ready, glb_psum_valid, fifo_count, cfg_err, glb_psum_data);
    end
    tick();
    pe_psum_valid = 4'b0;
    rstn = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (rst_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_busy_edge1: busy=%b, required 1", rst_busy);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rst_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_edge2: busy=%b, required 0", rst_busy);
    end
    tick();
  endtask

  task automatic test_single();
    cfg_load = 1'b1; cfg_y_id = 2'd2;
    tick();
    cfg_load = 1'b0;
    cur_y = 2'd2;
    glb_psum_ready = 1'b1;
    pe_d[1] = 32'h0000_1234;
    pe_psum_valid = 4'b0010;
    @(negedge clk);
    checks++;
    if (pe_psum_ready !== 4'b0010) begin
      errors++;
      $display("FAIL single_grant: ready=%b, required 0010", pe_psum_ready);
    end
    tick();
    pe_psum_valid = 4'b0;
    @(negedge clk);
    checks++;
    if (glb_psum_valid !== 1'b1 || glb_psum_data !== 32'h0000_1234 ||
        glb_psum_x_id !== 2'd1 || glb_psum_y_id !== 2'd2) begin
      errors++;
      $display("FAIL single_out: v=%b d=%h x=%0d y=%0d, required 1 00001234 1 2",
               glb_psum_valid, glb_psum_data, glb_psum_x_id, glb_psum_y_id);
    end
    tick();
    @(negedge clk);
    checks++;
    if (fifo_count !== 3'd0 || glb_psum_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drained: count=%0d v=%b, required 0 0", fifo_count, glb_psum_valid);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    do_flush();
    glb_psum_ready = 1'b1;
    for (int i = 0; i < 4; i++) pe_d[i] = 32'hA000_0000 + 32'(i);
    pe_psum_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      exp_g = 4'b0001 << (k % 4);
      @(negedge clk);
      checks++;
      if (pe_psum_ready !== exp_g) begin
        errors++;
        $display("FAIL rr_grant[%0d]: ready=%b, required %b", k, pe_psum_ready, exp_g);
      end
      if (k >= 1) begin
        checks++;
        if (glb_psum_valid !== 1'b1 || glb_psum_x_id !== 2'((k-1) % 4)) begin
          errors++;
          $display("FAIL rr_out[%0d]: v=%b x=%0d, required 1 %0d", k, glb_psum_valid, glb_psum_x_id, (k-1) % 4);
        end
      end
      tick();
    end
    pe_psum_valid = 4'b0;
    drain(10);
  endtask

  task automatic test_full();
    int j;
    int budget;
    logic hs;
    glb_psum_ready = 1'b0;
    j = 0;
    pe_d[0] = 32'h0000_5000;
    pe_psum_valid = 4'b0001;
    repeat (6) begin
      @(negedge clk);
      hs = pe_psum_ready[0];
      tick();
      if (hs) begin
        j++;
        pe_d[0] = 32'h0000_5000 + 32'(j);
      end
    end
    @(negedge clk);
    checks++;
    if (fifo_count !== 3'd4 || j != 4 || pe_psum_ready !== 4'b0 || glb_psum_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_hold: count=%0d accepted=%0d ready=%b gv=%b, required 4 4 0000 1",
               fifo_count, j, pe_psum_ready, glb_psum_valid);
    end
    tick();
    glb_psum_ready = 1'b1;
    budget = 0;
    while (j < 6 && budget < 20) begin
      @(negedge clk);
      checks++;
      if (pe_psum_ready !== 4'b0001 || glb_psum_valid !== 1'b1 || fifo_count !== 3'd4) begin
        errors++;
        $display("FAIL full_pushpop: ready=%b gv=%b count=%0d, required 0001 1 4",
                 pe_psum_ready, glb_psum_valid, fifo_count);
      end
      hs = pe_psum_ready[0];
      tick();
      if (hs) begin
        j++;
        pe_d[0] = 32'h0000_5000 + 32'(j);
        if (j == 6) pe_psum_valid = 4'b0;
      end
      budget++;
    end
    pe_psum_valid = 4'b0;
    checks++;
    if (j != 6) begin
      errors++;
      $display("FAIL full_accept_count: accepted=%0d, required 6", j);
    end
    drain(10);
  endtask

  task automatic test_flush();
    glb_psum_ready = 1'b0;
    pe_psum_valid = 4'b0100;
    pe_d[2] = 32'h0000_2001;
    tick();
    pe_d[2] = 32'h0000_2002;
    tick();
    pe_psum_valid = 4'b0;
    @(negedge clk);
    checks++;
    if (fifo_count !== 3'd2) begin
      errors++;
      $display("FAIL flush_pre_count: count=%0d, required 2", fifo_count);
    end
    tick();
    pe_d[2] = 32'h0000_2222;
    pe_d[3] = 32'h0000_3333;
    pe_psum_valid = 4'b1100;
    glb_psum_ready = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (pe_psum_ready !== 4'b0) begin
      errors++;
      $display("FAIL flush_cycle_grant: ready=%b, required 0000", pe_psum_ready);
    end
    tick();
    flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (rst_busy !== 1'b1 || fifo_count !== 3'd0 || pe_psum_ready !== 4'b0 || glb_psum_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_busy[%0d]: busy=%b count=%0d ready=%b gv=%b, required 1 0 0000 0",
                 k, rst_busy, fifo_count, pe_psum_ready, glb_psum_valid);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (rst_busy !== 1'b0 || pe_psum_ready !== 4'b0100) begin
      errors++;
      $display("FAIL flush_rr_restart: busy=%b ready=%b, required 0 0100", rst_busy, pe_psum_ready);
    end
    tick();
    pe_psum_valid = 4'b1000;
    @(negedge clk);
    checks++;
    if (pe_psum_ready !== 4'b1000) begin
      errors++;
      $display("FAIL flush_next_grant: ready=%b, required 1000", pe_psum_ready);
    end
    tick();
    pe_psum_valid = 4'b0;
    drain(10);
  endtask

  task automatic test_cfg();
    glb_psum_ready = 1'b0;
    pe_d[0] = 32'h0000_6001;
    pe_psum_valid = 4'b0001;
    tick();
    pe_psum_valid = 4'b0;
    cfg_load = 1'b1;
    cfg_y_id = 2'd3;
    tick();
    cfg_load = 1'b0;
    @(negedge clk);
    checks++;
    if (cfg_err !== 1'b1 || glb_psum_y_id !== 2'd2 || fifo_count !== 3'd1) begin
      errors++;
      $display("FAIL cfg_rejected: err=%b y=%0d count=%0d, required 1 2 1", cfg_err, glb_psum_y_id, fifo_count);
    end
    tick();
    drain(10);
    cfg_load = 1'b1;
    cfg_y_id = 2'd3;
    tick();
    cfg_load = 1'b0;
    cur_y = 2'd3;
    pe_d[1] = 32'h0000_6002;
    pe_psum_valid = 4'b0010;
    @(negedge clk);
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL cfg_err_sticky: err=%b, required 1", cfg_err);
    end
    tick();
    pe_psum_valid = 4'b0;
    @(negedge clk);
    checks++;
    if (glb_psum_valid !== 1'b1 || glb_psum_y_id !== 2'd3 || glb_psum_x_id !== 2'd1) begin
      errors++;
      $display("FAIL cfg_new_y: gv=%b y=%0d x=%0d, required 1 3 1", glb_psum_valid, glb_psum_y_id, glb_psum_x_id);
    end
    tick();
    drain(10);
    do_flush();
    @(negedge clk);
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_flush: err=%b, required 0", cfg_err);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    glb_psum_ready = 1'b0;
    pe_psum_valid = 4'b0001;
    for (int k = 1; k <= 3; k++) begin
      pe_d[0] = 32'h0000_7000 + 32'(k);
      tick();
    end
    pe_d[0] = 32'h0000_7004;
    checks++;
    if (fifo_count !== 3'd3) begin
      errors++;
      $display("FAIL midrst_pre_count: count=%0d, required 3", fifo_count);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (rst_busy !== 1'b1 || glb_psum_valid !== 1'b0 || fifo_count !== 3'd0 || pe_psum_ready !== 4'b0 ||
        glb_psum_data !== 32'h0 || glb_psum_x_id !== 2'd0 || glb_psum_y_id !== 2'd0 || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: busy=%b gv=%b cnt=%0d rdy=%b d=%h x=%0d y=%0d, required 1 0 0 0000 0 0 0",
               rst_busy, glb_psum_valid, fifo_count, pe_psum_ready, glb_psum_data, glb_psum_x_id, glb_psum_y_id);
    end
    repeat (2) tick();
    rstn = 1'b1;
    pe_psum_valid = 4'b0;
    glb_psum_ready = 1'b1;
    cur_y = 2'd0;
    @(negedge clk);
    tick();
    @(negedge clk);
    checks++;
    if (rst_busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_busy1: busy=%b, required 1", rst_busy);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (rst_busy !== 1'b0 || glb_psum_valid !== 1'b0 || fifo_count !== 3'd0) begin
        errors++;
        $display("FAIL midrst_stale[%0d]: busy=%b gv=%b cnt=%0d, required 0 0 0", k, rst_busy, glb_psum_valid, fifo_count);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_flush();
    test_cfg();
    test_reset_mid();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d entries never emerged, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
